// File: rtl/player_hit_ctrl.sv
// Latches player/moon overlap per frame, resolves hits at frame_tick, tracks lives/invuln/game-over.
// All outputs registered; updates land one cycle after the frame_tick or restart edge.
module player_hit_ctrl #(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BLINK_BIT     = 3,
  parameter int unsigned SPEED_STEP    = 200000,
  parameter int unsigned SPEED_MAX     = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick_i,
  input  logic        video_on_i,
  input  logic        player_on_i,
  input  logic        moon_on_i,
  input  logic        restart_i,
  output logic [2:0]  lives_o,
  output logic        invuln_o,
  output logic        player_visible_o,
  output logic        hit_pulse_o,
  output logic        game_over_o,
  output logic [25:0] speed_offset_o
);

  typedef enum logic [1:0] {S_ALIVE, S_INVULN, S_OVER} state_t;

  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        ov_q, ov_d;
  logic        hit_d;
  logic [25:0] speed_q, speed_d;
  logic        cur_ov, eval;
  logic [26:0] speed_sum;

  assign cur_ov    = video_on_i & player_on_i & moon_on_i;
  assign eval      = ov_q | cur_ov;
  assign speed_sum = {1'b0, speed_q} + 27'(SPEED_STEP);

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    speed_d   = speed_q;
    hit_d     = 1'b0;
    ov_d      = ov_q | cur_ov;
    if (restart_i) begin
      state_d   = S_ALIVE;
      lives_d   = 3'(LIVES);
      inv_cnt_d = '0;
      speed_d   = '0;
      ov_d      = 1'b0;
    end else if (frame_tick_i) begin
      // Same-cycle overlap is folded into eval before the latch clears.
      ov_d = 1'b0;
      case (state_q)
        S_ALIVE: begin
          if (eval) begin
            hit_d   = 1'b1;
            speed_d = (speed_sum > 27'(SPEED_MAX)) ? 26'(SPEED_MAX) : speed_sum[25:0];
            if (lives_q == 3'd1) begin
              lives_d = 3'd0;
              state_d = S_OVER;
            end else begin
              lives_d   = lives_q - 3'd1;
              inv_cnt_d = 8'(INVULN_FRAMES - 1);
              state_d   = S_INVULN;
            end
          end
        end
        S_INVULN: begin
          if (inv_cnt_q == 8'd0) state_d = S_ALIVE;
          else                   inv_cnt_d = inv_cnt_q - 8'd1;
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_ALIVE;
      lives_q          <= 3'(LIVES);
      inv_cnt_q        <= '0;
      ov_q             <= 1'b0;
      speed_q          <= '0;
      hit_pulse_o      <= 1'b0;
      invuln_o         <= 1'b0;
      game_over_o      <= 1'b0;
      player_visible_o <= 1'b1;
    end else begin
      state_q          <= state_d;
      lives_q          <= lives_d;
      inv_cnt_q        <= inv_cnt_d;
      ov_q             <= ov_d;
      speed_q          <= speed_d;
      hit_pulse_o      <= hit_d;
      invuln_o         <= (state_d == S_INVULN);
      game_over_o      <= (state_d == S_OVER);
      player_visible_o <= (state_d == S_ALIVE) |
                          ((state_d == S_INVULN) & ~inv_cnt_d[BLINK_BIT]);
    end
  end

  assign lives_o        = lives_q;
  assign speed_offset_o = speed_q;

endmodule
